// File: rtl/time_report_scheduler.sv
`timescale 1ns/1ps
// Serialises a time snapshot into an ASCII "HH:MM:SS\r\n" frame for a UART sender.
// Define TIME_REPORT_MSEC_EN to add i_msec and emit "HH:MM:SS.cc\r\n".
module time_report_scheduler #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
`ifdef TIME_REPORT_MSEC_EN
    input  logic [6:0] i_msec,
`endif
    input  logic       i_req,
    input  logic       i_auto_en,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_frame_done
);

`ifdef TIME_REPORT_MSEC_EN
    localparam logic [3:0] LAST_IDX = 4'd12;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state, state_nxt;
    logic [3:0] idx;
    logic [7:0] gap_cnt;
    logic       pending;
    logic       prime;
    logic [5:0] prev_sec;
    logic [4:0] snap_hour;
    logic [5:0] snap_min;
    logic [5:0] snap_sec;
`ifdef TIME_REPORT_MSEC_EN
    logic [6:0] snap_msec;
`endif

    logic       auto_trig;
    logic       trig;
    logic       start;
    logic       hs;
    logic       last;
    logic [7:0] frame_byte;

    function automatic logic [7:0] tens_ascii(input logic [6:0] v);
        return 8'h30 + 8'(v / 7'd10);
    endfunction

    function automatic logic [7:0] ones_ascii(input logic [6:0] v);
        return 8'h30 + 8'(v % 7'd10);
    endfunction

    assign auto_trig = i_auto_en & prime & (i_sec != prev_sec);
    assign trig      = i_req | auto_trig;
    assign start     = (state == IDLE) & (trig | pending) & (gap_cnt == 8'd0);
    assign hs        = (state == SEND) & i_tx_ready;
    assign last      = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt    = state;
        o_tx_valid   = 1'b0;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SEND;
            SEND: begin
                o_tx_valid = 1'b1;
                o_busy     = 1'b1;
                if (hs && last) begin
                    o_frame_done = ~reset;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        prev_sec <= i_sec;
        if (reset) begin
            idx       <= 4'd0;
            gap_cnt   <= 8'd0;
            pending   <= 1'b0;
            prime     <= 1'b0;
            snap_hour <= 5'd0;
            snap_min  <= 6'd0;
            snap_sec  <= 6'd0;
`ifdef TIME_REPORT_MSEC_EN
            snap_msec <= 7'd0;
`endif
        end else begin
            prime <= 1'b1;
            if (start) begin
                snap_hour <= i_hour;
                snap_min  <= i_min;
                snap_sec  <= i_sec;
`ifdef TIME_REPORT_MSEC_EN
                snap_msec <= i_msec;
`endif
                pending   <= 1'b0;
                idx       <= 4'd0;
            end else if (trig) begin
                // Not startable right now: remember one frame, further triggers coalesce.
                pending <= 1'b1;
            end
            if (hs) idx <= last ? 4'd0 : idx + 4'd1;
            if (hs && last)
                gap_cnt <= GAP_LOAD;
            else if (state == IDLE && gap_cnt != 8'd0)
                gap_cnt <= gap_cnt - 8'd1;
        end
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx)
            4'd0:  frame_byte = tens_ascii({2'b00, snap_hour});
            4'd1:  frame_byte = ones_ascii({2'b00, snap_hour});
            4'd2:  frame_byte = 8'h3A;
            4'd3:  frame_byte = tens_ascii({1'b0, snap_min});
            4'd4:  frame_byte = ones_ascii({1'b0, snap_min});
            4'd5:  frame_byte = 8'h3A;
            4'd6:  frame_byte = tens_ascii({1'b0, snap_sec});
            4'd7:  frame_byte = ones_ascii({1'b0, snap_sec});
`ifdef TIME_REPORT_MSEC_EN
            4'd8:  frame_byte = 8'h2E;
            4'd9:  frame_byte = tens_ascii(snap_msec);
            4'd10: frame_byte = ones_ascii(snap_msec);
            4'd11: frame_byte = 8'h0D;
            4'd12: frame_byte = 8'h0A;
`else
            4'd8:  frame_byte = 8'h0D;
            4'd9:  frame_byte = 8'h0A;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    assign o_tx_data = (state == SEND) ? frame_byte : 8'h00;

endmodule

// File: tb/tb_time_report_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for time_report_scheduler: table-driven frames plus scoreboarded
// corner sequences (backpressure, coalescing, auto report, inter-frame gap, reset abort).
module tb_time_report_scheduler;

`ifdef TIME_REPORT_MSEC_EN
    localparam int FLEN  = 13;
    localparam bit MSEC  = 1'b1;
`else
    localparam int FLEN  = 10;
    localparam bit MSEC  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] hour;
    logic [5:0] t_min;
    logic [5:0] sec;
    logic [6:0] msec;
    logic       req, auto_en, ready;
    logic       req4, ready4;
    logic [7:0] data0, data4;
    logic       valid0, busy0, done0;
    logic       valid4, busy4, done4;

    always #5 clk = ~clk;

    time_report_scheduler #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .i_hour(hour), .i_min(t_min), .i_sec(sec),
`ifdef TIME_REPORT_MSEC_EN
        .i_msec(msec),
`endif
        .i_req(req), .i_auto_en(auto_en), .o_tx_data(data0), .o_tx_valid(valid0),
        .i_tx_ready(ready), .o_busy(busy0), .o_frame_done(done0)
    );

    time_report_scheduler #(.GAP_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .i_hour(hour), .i_min(t_min), .i_sec(sec),
`ifdef TIME_REPORT_MSEC_EN
        .i_msec(msec),
`endif
        .i_req(req4), .i_auto_en(1'b0), .o_tx_data(data4), .o_tx_valid(valid4),
        .i_tx_ready(ready4), .o_busy(busy4), .o_frame_done(done4)
    );

    typedef struct {
        logic [4:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic [6:0]  ms;
        logic [63:0] hms;
        logic [23:0] mss;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    vec_t tbl[5];
    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic stall_prev = 1'b0;
    logic [7:0] stall_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                            input logic [6:0] ms);
        hour = h; t_min = m; sec = s; msec = ms;
    endtask

    task automatic push_text(input logic [63:0] hms, input logic [23:0] mss, input int n);
        logic [7:0] b[13];
        int len = 0;
        for (int i = 0; i < 8; i++) b[len++] = hms[8*(7-i) +: 8];
        if (MSEC) begin
            for (int i = 0; i < 3; i++) b[len++] = mss[8*(2-i) +: 8];
        end
        b[len++] = 8'h0D;
        b[len++] = 8'h0A;
        for (int i = 0; i < n; i++) exp_q.push_back('{b[i], (i == len - 1)});
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 500; k++) begin
            if (!busy0 && exp_q.size() == 0) return;
            step();
        end
        fail("wait_idle_timeout");
    endtask

    // Scoreboard monitor for dut0: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (stall_prev) begin
            check("hold_valid", {31'd0, valid0}, 32'd1);
            check("hold_data", {24'd0, data0}, {24'd0, stall_data});
        end
        stall_prev = valid0 & ~ready & ~reset;
        stall_data = data0;
        if (valid0 && ready) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_byte");
            end else begin
                e = exp_q.pop_front();
                check("byte", {24'd0, data0}, {24'd0, e.b});
                check("frame_done", {31'd0, done0}, {31'd0, e.last});
            end
        end else begin
            check("frame_done_quiet", {31'd0, done0}, 32'd0);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        tbl[0] = '{5'd13, 6'd5,  6'd42, 7'd7,  "13:05:42", ".07"};
        tbl[1] = '{5'd0,  6'd0,  6'd0,  7'd0,  "00:00:00", ".00"};
        tbl[2] = '{5'd23, 6'd59, 6'd59, 7'd99, "23:59:59", ".99"};
        tbl[3] = '{5'd31, 6'd63, 6'd63, 7'd45, "31:63:63", ".45"};
        tbl[4] = '{5'd9,  6'd10, 6'd1,  7'd50, "09:10:01", ".50"};

        // Reset state, with auto enabled and the second moving exactly at release.
        reset = 1'b1; req = 1'b0; req4 = 1'b0; ready = 1'b1; ready4 = 1'b1;
        auto_en = 1'b1;
        set_time(5'd13, 6'd5, 6'd5, 7'd7);
        repeat (3) step();
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_data", {24'd0, data0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_valid4", {31'd0, valid4}, 32'd0);
        reset = 1'b0;
        sec   = 6'd0;
        b = 0;
        repeat (200) begin step(); if (busy0) b++; end
        check("no_frame_at_release", b, 0);

        // Auto report on each seconds change.
        for (int s = 1; s <= 2; s++) begin
            sec = 6'(s);
            push_text((s == 1) ? "13:05:01" : "13:05:02", ".07", FLEN);
            b = 0;
            repeat (200) begin step(); if (busy0) b++; end
            check("auto_frame_cycles", b, FLEN);
        end
        auto_en = 1'b0;
        wait_idle();

        // Table-driven frames, ready held high.
        for (int i = 0; i < 5; i++) begin
            set_time(tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].ms);
            step();
            push_text(tbl[i].hms, tbl[i].mss, FLEN);
            pulse_req();
            check("latency_valid", {31'd0, valid0}, 32'd1);
            b = 0;
            for (int k = 0; k < 50; k++) begin
                if (!busy0) break;
                b++;
                step();
            end
            check("busy_cycles", b, FLEN);
            wait_idle();
        end

        // Backpressure with ready pattern 1,0,0 repeating.
        set_time(tbl[0].h, tbl[0].m, tbl[0].s, tbl[0].ms);
        push_text(tbl[0].hms, tbl[0].mss, FLEN);
        pulse_req();
        for (int c = 0; c < 100; c++) begin
            ready = (c % 3 == 0);
            step();
            if (!busy0 && exp_q.size() == 0) break;
        end
        ready = 1'b1;
        wait_idle();

        // Snapshot hold and coalescing of three mid-frame requests.
        push_text("13:05:42", ".07", FLEN);
        pulse_req();
        step(); step();
        sec = 6'd43;
        pulse_req(); step();
        pulse_req(); step();
        pulse_req();
        push_text("13:05:43", ".07", FLEN);
        for (int k = 0; k < 50; k++) begin
            if (done0) break;
            step();
        end
        step();
        check("gap0_idle", {31'd0, valid0}, 32'd0);
        step();
        check("gap0_restart", {31'd0, valid0}, 32'd1);
        check("gap0_first_byte", {24'd0, data0}, 32'h31);
        wait_idle();
        b = 0;
        repeat (30) begin step(); if (busy0) b++; end
        check("no_third_frame", b, 0);

        // GAP_CYCLES=4 instance: request lands on the final byte.
        req4 = 1'b1; step(); req4 = 1'b0;
        check("gap4_start", {31'd0, valid4}, 32'd1);
        for (int k = 0; k < 50; k++) begin
            if (done4) break;
            step();
        end
        req4 = 1'b1; step(); req4 = 1'b0;
        b = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid4) break;
            b++;
            step();
        end
        check("gap4_idle_cycles", b, 5);
        check("gap4_first_byte", {24'd0, data4}, 32'h31);
        for (int k = 0; k < 50; k++) begin
            if (!busy4) break;
            step();
        end
        check("gap4_done", {31'd0, busy4}, 32'd0);

        // Reset asserted while byte index 4 is offered.
        push_text("13:05:43", ".07", 4);
        pulse_req();
        repeat (4) step();
        reset = 1'b1; ready = 1'b0;
        step();
        check("abort_valid", {31'd0, valid0}, 32'd0);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_done", {31'd0, done0}, 32'd0);
        reset = 1'b0; ready = 1'b1;
        step();
        check("abort_no_pending", {31'd0, valid0}, 32'd0);
        push_text("13:05:43", ".07", FLEN);
        pulse_req();
        check("restart_first_byte", {24'd0, data0}, 32'h31);
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
